phy_tx_serializer: RTL and testbench

- Transmit end of the PHY serial link. Takes four 8-bit lanes with per-lane valids and emits one serial bit stream, MSB first, lanes in order 0..3, on clk_32f.
- After reset it sends comma frames (BC) so the receiver can lock. It then sends lane data, substituting the idle symbol (7C) for any lane whose valid is low.
- Its output drives the data input of the PHY receiver.

---
 rtl/phy_tx_serializer_if.sv | 23 ++
 rtl/phy_tx_serializer.sv | 118 +++++++++++
 tb/tb_phy_tx_serializer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/phy_tx_serializer_if.sv
// Lane bus feeding the PHY transmit serializer: four bytes and their valids.
// The producer drives through the master modport; the serializer samples the
// bus through the slave modport once per frame.
interface phy_tx_serializer_if;
  logic [7:0] data_in_0;
  logic [7:0] data_in_1;
  logic [7:0] data_in_2;
  logic [7:0] data_in_3;
  logic       valid_in_0;
  logic       valid_in_1;
  logic       valid_in_2;
  logic       valid_in_3;

  modport master (
    output data_in_0, data_in_1, data_in_2, data_in_3,
    output valid_in_0, valid_in_1, valid_in_2, valid_in_3
  );

  modport slave (
    input data_in_0, data_in_1, data_in_2, data_in_3,
    input valid_in_0, valid_in_1, valid_in_2, valid_in_3
  );
endinterface

// File: rtl/phy_tx_serializer.sv
// PHY transmit serializer. Emits 32-bit frames (lanes 0..3, MSB first) on
// clk_32f. After reset it sends SYNC_FRAMES all-comma frames so the receiver
// can lock, then sends sampled lane bytes, with IDLE in place of any lane whose
// valid is low. Lane inputs are sampled only at the frame capture edge.
module phy_tx_serializer #(
  parameter int unsigned SYNC_FRAMES = 1,
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter logic [7:0]  IDLE        = 8'h7C
) (
  input  logic                 clk_32f,
  input  logic                 reset_L,
  phy_tx_serializer_if.slave   lanes,
  output logic                 data_out,
  output logic                 active,
  output logic                 load
);

  localparam logic [3:0] SYNC_LIM = 4'(SYNC_FRAMES);

  typedef enum logic {ST_SYNC, ST_ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [1:0]      lane_cnt_q, lane_cnt_d;
  logic [3:0]      sync_cnt_q, sync_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [3:0][7:0] hold_q, hold_d;
  logic            data_out_q, data_out_d;
  logic            active_q, active_d;
  logic            load_q, load_d;

  logic            capture;
  logic [7:0]      next_byte;

  // A frame boundary: the first bit of lane 0 is about to be launched.
  assign capture = (bit_cnt_q == 3'd0) && (lane_cnt_q == 2'd0);

  // Next-state: frame counters, sync/active decision, lane capture and bit shifting.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q + 3'd1;
    lane_cnt_d = lane_cnt_q;
    sync_cnt_d = sync_cnt_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    data_out_d = data_out_q;
    active_d   = active_q;
    load_d     = (bit_cnt_q == 3'd7) && (lane_cnt_q == 2'd3);
    next_byte  = hold_q[lane_cnt_q];

    if (bit_cnt_q == 3'd7) begin
      lane_cnt_d = lane_cnt_q + 2'd1;
    end

    if (capture) begin
      if ((state_q == ST_SYNC) && (sync_cnt_q < SYNC_LIM)) begin
        // Comma frame: lane inputs are deliberately ignored.
        hold_d     = {4{COMMA}};
        sync_cnt_d = sync_cnt_q + 4'd1;
      end else begin
        state_d   = ST_ACTIVE;
        active_d  = 1'b1;
        hold_d[0] = lanes.valid_in_0 ? lanes.data_in_0 : IDLE;
        hold_d[1] = lanes.valid_in_1 ? lanes.data_in_1 : IDLE;
        hold_d[2] = lanes.valid_in_2 ? lanes.data_in_2 : IDLE;
        hold_d[3] = lanes.valid_in_3 ? lanes.data_in_3 : IDLE;
      end
      // The lane 0 byte leaves on the capture edge itself, so bypass the holding register.
      next_byte = hold_d[0];
    end

    if (bit_cnt_q == 3'd0) begin
      data_out_d = next_byte[7];
      shift_d    = next_byte;
    end else begin
      // shift_q[7] is already on the line; shift left so the next bit sits at [6].
      data_out_d = shift_q[6];
      shift_d    = {shift_q[6:0], 1'b0};
    end
  end

  // Control state: FSM state and frame/sync counters.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= ST_SYNC;
      bit_cnt_q  <= 3'd0;
      lane_cnt_q <= 2'd0;
      sync_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      lane_cnt_q <= lane_cnt_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  // Datapath and registered outputs; a mid-frame reset drops the byte in flight.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      shift_q    <= 8'd0;
      hold_q     <= '0;
      data_out_q <= 1'b0;
      active_q   <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      data_out_q <= data_out_d;
      active_q   <= active_d;
      load_q     <= load_d;
    end
  end

  assign data_out = data_out_q;
  assign active   = active_q;
  assign load     = load_q;

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Bench for phy_tx_serializer: three instances (SYNC_FRAMES = 1, 3, 0) share
// clock, reset and lane stimulus. A frame-level model decides each frame's four
// bytes from the sync count and the lane values held at the capture edge, then
// every output bit, active and load are compared after each edge.
module tb_phy_tx_serializer;

  logic clk_32f = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk_32f = ~clk_32f;

  phy_tx_serializer_if if_a ();
  phy_tx_serializer_if if_b ();
  phy_tx_serializer_if if_c ();

  logic [2:0] dout, act, ld;

  phy_tx_serializer #(.SYNC_FRAMES(1)) u_s1 (
    .clk_32f(clk_32f), .reset_L(reset_L), .lanes(if_a.slave),
    .data_out(dout[0]), .active(act[0]), .load(ld[0]));
  phy_tx_serializer #(.SYNC_FRAMES(3)) u_s3 (
    .clk_32f(clk_32f), .reset_L(reset_L), .lanes(if_b.slave),
    .data_out(dout[1]), .active(act[1]), .load(ld[1]));
  phy_tx_serializer #(.SYNC_FRAMES(0)) u_s0 (
    .clk_32f(clk_32f), .reset_L(reset_L), .lanes(if_c.slave),
    .data_out(dout[2]), .active(act[2]), .load(ld[2]));

  int checks = 0;
  int failures = 0;
  int frame_idx = 0;
  logic [7:0] cur_d [4];
  logic [3:0] cur_v;

  function automatic int sync_frames(input int d);
    case (d)
      0: return 1;
      1: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic apply_inputs();
    if_a.data_in_0 = cur_d[0]; if_a.data_in_1 = cur_d[1];
    if_a.data_in_2 = cur_d[2]; if_a.data_in_3 = cur_d[3];
    if_a.valid_in_0 = cur_v[0]; if_a.valid_in_1 = cur_v[1];
    if_a.valid_in_2 = cur_v[2]; if_a.valid_in_3 = cur_v[3];
    if_b.data_in_0 = cur_d[0]; if_b.data_in_1 = cur_d[1];
    if_b.data_in_2 = cur_d[2]; if_b.data_in_3 = cur_d[3];
    if_b.valid_in_0 = cur_v[0]; if_b.valid_in_1 = cur_v[1];
    if_b.valid_in_2 = cur_v[2]; if_b.valid_in_3 = cur_v[3];
    if_c.data_in_0 = cur_d[0]; if_c.data_in_1 = cur_d[1];
    if_c.data_in_2 = cur_d[2]; if_c.data_in_3 = cur_d[3];
    if_c.valid_in_0 = cur_v[0]; if_c.valid_in_1 = cur_v[1];
    if_c.valid_in_2 = cur_v[2]; if_c.valid_in_3 = cur_v[3];
  endtask

  task automatic drive(input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3,
                       input logic [3:0] v);
    cur_d[0] = d0; cur_d[1] = d1; cur_d[2] = d2; cur_d[3] = d3;
    cur_v = v;
    apply_inputs();
  endtask

  task automatic drive_random();
    drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
  endtask

  // Runs nedges edges of the current frame, starting at its capture edge.
  // mode 1: random input change after edge 4; mode 2: lane 2 data becomes 55 after edge 4.
  task automatic run_frame(input string name, input int nedges, input int mode);
    logic [7:0] bytes [3][4];
    logic [7:0] b;
    logic exp_bit, exp_act, exp_ld;
    int pos;
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 4; k++)
        bytes[d][k] = (frame_idx < sync_frames(d)) ? 8'hBC : (cur_v[k] ? cur_d[k] : 8'h7C);
    for (int j = 1; j <= nedges; j++) begin
      @(posedge clk_32f); #1;
      if (j == 4 && mode == 1) drive_random();
      if (j == 4 && mode == 2) begin cur_d[2] = 8'h55; apply_inputs(); end
      pos = j - 1;
      for (int d = 0; d < 3; d++) begin
        b = bytes[d][pos / 8];
        exp_bit = b[7 - (pos % 8)];
        exp_act = (frame_idx >= sync_frames(d));
        exp_ld = (j == 32);
        checks++;
        if (dout[d] !== exp_bit) begin
          failures++;
          $display("FAIL %s data_out dut%0d frame%0d bit%0d: got %b expected %b",
                   name, d, frame_idx, pos, dout[d], exp_bit);
        end
        checks++;
        if (act[d] !== exp_act) begin
          failures++;
          $display("FAIL %s active dut%0d frame%0d bit%0d: got %b expected %b",
                   name, d, frame_idx, pos, act[d], exp_act);
        end
        checks++;
        if (ld[d] !== exp_ld) begin
          failures++;
          $display("FAIL %s load dut%0d frame%0d bit%0d: got %b expected %b",
                   name, d, frame_idx, pos, ld[d], exp_ld);
        end
      end
    end
    if (nedges == 32) frame_idx++;
  endtask

  task automatic check_outputs_zero(input string name);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({dout[d], act[d], ld[d]} !== 3'b000) begin
        failures++;
        $display("FAIL %s dut%0d: data_out/active/load=%b%b%b expected 000",
                 name, d, dout[d], act[d], ld[d]);
      end
    end
  endtask

  task automatic test_reset();
    drive(8'hFF, 8'hEE, 8'hDD, 8'hCC, 4'hF);
    reset_L = 1'b0;
    repeat (2) @(posedge clk_32f);
    #1;
    check_outputs_zero("reset_state");
    reset_L = 1'b1;
    frame_idx = 0;
  endtask

  task automatic test_sync_then_data();
    for (int f = 0; f < 4; f++) run_frame("sync_then_data", 32, 0);
  endtask

  task automatic test_idle_subst();
    drive(8'hBB, 8'hAA, 8'h99, 8'h88, 4'b0101);
    run_frame("idle_subst", 32, 0);
  endtask

  task automatic test_input_stability();
    drive(8'h12, 8'h34, 8'h77, 8'h56, 4'hF);
    run_frame("stability_hold", 32, 2);
    run_frame("stability_next", 32, 0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 6; f++) begin
      drive_random();
      run_frame("back_to_back", 32, 1);
    end
  endtask

  task automatic test_mid_reset();
    drive_random();
    run_frame("pre_reset", 18, 0);
    #2 reset_L = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    repeat (2) @(posedge clk_32f);
    #1;
    check_outputs_zero("reset_held");
    reset_L = 1'b1;
    frame_idx = 0;
    for (int f = 0; f < 5; f++) begin
      drive_random();
      run_frame("after_reset", 32, 1);
    end
  endtask

  initial begin
    test_reset();
    test_sync_then_data();
    test_idle_subst();
    test_input_stability();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
